// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// The master side is the pipeline; the slave side is mdu_iter.
interface mdu_iter_if #(
  parameter int XLEN = 32
) ();
  logic            valid_in;
  logic            ready;
  logic            flush;
  logic [4:0]      alu_op;
  logic            s_32;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            valid_out;
  logic [XLEN-1:0] result;

  modport master (
    output valid_in, flush, alu_op, s_32, rs1, rs2,
    input  ready, busy, valid_out, result
  );

  modport slave (
    input  valid_in, flush, alu_op, s_32, rs1, rs2,
    output ready, busy, valid_out, result
  );
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, UNROLL bits per cycle, sign fix-up at the end.
module mdu_iter #(
  parameter int XLEN       = 32,
  parameter int UNROLL     = 1,
  parameter int ENABLE_MUL = 1,
  parameter int ENABLE_DIV = 1
) (
  input  logic      clock,
  input  logic      reset,
  mdu_iter_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN / UNROLL - 1);
  localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32 / UNROLL - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic signed [31:0]     s;
    logic signed [XLEN-1:0] r;
    s = x;
    r = s;
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2:0]        op_q;
  logic              w32_q, a_neg_q, b_neg_q, dz_q, ovf_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] mc_q, acc_q;

  logic              ready, accept, load;
  logic              w32_in, is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic              dz_in, ovf_in, dis_in;
  logic [XLEN-1:0]   opa_in, opb_in, mag_a, mag_b, min_w;
  logic [CNT_W-1:0]  cnt_load;

  // Operand decode at accept: effective width, signedness, magnitudes, special cases
  always_comb begin
    w32_in    = (XLEN == 64) && bus.s_32;
    is_div_in = bus.alu_op[2];
    a_sgn_in  = is_div_in ? !bus.alu_op[0] : (bus.alu_op[1:0] != 2'b11);
    b_sgn_in  = is_div_in ? !bus.alu_op[0] : !bus.alu_op[1];
    if (w32_in) begin
      opa_in = a_sgn_in ? sext32(bus.rs1[31:0]) : XLEN'(bus.rs1[31:0]);
      opb_in = b_sgn_in ? sext32(bus.rs2[31:0]) : XLEN'(bus.rs2[31:0]);
      min_w  = sext32(32'h8000_0000);
    end else begin
      opa_in = bus.rs1;
      opb_in = bus.rs2;
      min_w  = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg_in = a_sgn_in && opa_in[XLEN-1];
    b_neg_in = b_sgn_in && opb_in[XLEN-1];
    mag_a    = a_neg_in ? -opa_in : opa_in;
    mag_b    = b_neg_in ? -opb_in : opb_in;
    dz_in    = is_div_in && (opb_in == '0);
    ovf_in   = is_div_in && a_sgn_in && (opa_in == min_w) && (opb_in == '1);
    dis_in   = is_div_in ? (ENABLE_DIV == 0) : (ENABLE_MUL == 0);
    cnt_load = w32_in ? N_WORD : N_FULL;
  end

  assign ready  = reset && (state_q == S_IDLE || state_q == S_DONE);
  assign accept = bus.valid_in && (bus.alu_op[4:3] == 2'b10) && ready && !bus.flush;

  logic [XLEN-1:0]   a_st;
  logic [2*XLEN-1:0] acc_st, mc_st, acc_step;
  logic [XLEN:0]     rem_st;

  // One CALC cycle: UNROLL multiply or restoring-divide steps
  always_comb begin
    a_st   = a_q;
    acc_st = acc_q;
    mc_st  = mc_q;
    rem_st = acc_q[XLEN:0];
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        // W-form dividends live in the low 32 bits, so bit 31 feeds the remainder
        rem_st = {rem_st[XLEN-1:0], (w32_q ? a_st[31] : a_st[XLEN-1])};
        a_st   = a_st << 1;
        if (rem_st >= {1'b0, b_q}) begin
          rem_st  = rem_st - {1'b0, b_q};
          a_st[0] = 1'b1;
        end
      end else begin
        if (a_st[0]) acc_st = acc_st + mc_st;
        mc_st = mc_st << 1;
        a_st  = a_st >> 1;
      end
    end
    acc_step = op_q[2] ? {{(XLEN-1){1'b0}}, rem_st} : acc_st;
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   rmd, dvd, raw, fix_res;

  always_comb begin
    prod_s = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    rmd    = acc_q[XLEN-1:0];
    dvd    = a_neg_q ? -a_q : a_q;
    if (!op_q[2]) begin
      if (op_q[1:0] == 2'b00) raw = prod_s[XLEN-1:0];
      else                    raw = w32_q ? XLEN'(prod_s[63:32]) : prod_s[2*XLEN-1:XLEN];
    end else if (dz_q) begin
      raw = op_q[1] ? dvd : '1;
    end else if (ovf_q) begin
      raw = op_q[1] ? '0 : dvd;
    end else if (op_q[1]) begin
      raw = a_neg_q ? -rmd : rmd;
    end else begin
      raw = (a_neg_q ^ b_neg_q) ? -a_q : a_q;
    end
    fix_res = w32_q ? sext32(raw[31:0]) : raw;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          load = 1'b1;
          if (dis_in) begin
            state_d  = S_DONE;
            result_d = '0;
          end else if (dz_in || ovf_in) begin
            state_d = S_FIXUP;
          end else begin
            state_d = S_CALC;
            cnt_d   = cnt_load;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == '0) state_d = S_FIXUP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIXUP: begin
        state_d  = S_DONE;
        result_d = fix_res;
      end
      default: state_d = S_IDLE;
    endcase
    // A DONE strobe already on the wire stays; everything else is dropped
    if (bus.flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      op_q    <= bus.alu_op[2:0];
      w32_q   <= w32_in;
      a_neg_q <= a_neg_in;
      b_neg_q <= b_neg_in;
      dz_q    <= dz_in;
      ovf_q   <= ovf_in;
      a_q     <= mag_a;
      b_q     <= mag_b;
      mc_q    <= {{XLEN{1'b0}}, mag_b};
      acc_q   <= '0;
    end else if (state_q == S_CALC) begin
      a_q   <= a_st;
      mc_q  <= mc_st;
      acc_q <= acc_step;
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = (bus.valid_in && state_q == S_IDLE) || state_q == S_CALC ||
                         state_q == S_FIXUP;
  assign bus.valid_out = (state_q == S_DONE);
  assign bus.result    = result_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit; successor to the single-cycle mul/div datapath hung off the EX stage.
- Covers RV32M, and RV64M including the W forms. Executes one operation at a time with a valid/ready handshake.
- Drives a busy flag into the hazard unit to stall IF/ID/EX. Honours pipeline flush.
- Replaces the combinational mul/div result path into the EX-stage result mux.

Parameters:
- XLEN, 32: datapath width; 32 or 64.
- UNROLL, 1: quotient/product bits retired per CALC cycle; 1, 2 or 4; must divide 32.
- ENABLE_MUL, 1: 0 makes MUL ops complete with result 0.
- ENABLE_DIV, 1: 0 makes DIV/REM ops complete with result 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- valid_in  in  1  operation request, held while the EX-stage instruction is a mul/div op.
- ready  out  1  unit can accept; high in IDLE or DONE.
- flush  in  1  abort current/pending operation (branch/exception kill).
- alu_op  in  5  [4:2]=100 mul, 101 div; [1:0] mul: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; div: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- s_32  in  1  W-form; ignored when XLEN=32.
- rs1  in  XLEN  operand A (forwarded).
- rs2  in  XLEN  operand B (forwarded).
- busy  out  1  stall request to hazard unit.
- valid_out  out  1  one-cycle result strobe.
- result  out  XLEN  result; stable from valid_out until the next accept.

Behaviour:
- Accept: valid_in && ready && !flush at a rising edge latches alu_op, s_32, operands; ready=0 afterwards.
- State IDLE→CALC on accept. If the op is div/rem with rs2==0, or signed overflow, go IDLE→FIXUP directly.
  - Signed overflow: most-negative / -1 at the effective width.
- Effective width W = 32 when s_32 && XLEN==64, else XLEN. N = W/UNROLL CALC cycles.
- Internally, signed operands are converted to magnitudes at accept. W-form operands use sign/zero-extended rs1[31:0], rs2[31:0].
- CALC:
  - Mul: shift-add on a 2W-bit accumulator, UNROLL bits per cycle.
  - Div: restoring, UNROLL quotient bits per cycle.
  - Iteration counter counts N-1 down to 0, then → FIXUP.
- FIXUP, one cycle:
  - Apply sign correction: product negated if signs differ (MULHSU: rs1 sign only). Quotient negated if dividend and divisor signs differ. Remainder takes dividend sign.
  - Select low W bits (MUL, DIV*, REM*) or high W bits (MULH*).
  - W-form result sign-extended bit 31 → XLEN. Then → DONE.
- DONE: valid_out=1 for exactly one cycle.
  - → CALC/FIXUP if a new accept occurs in DONE (back-to-back), else → IDLE.
- Latency, accept edge = cycle 0:
  - Normal op: valid_out high in cycle N+2.
  - Special-case div: valid_out high in cycle 2.
- Special cases, at width W:
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend.
  - Overflow: quotient = dividend; remainder = 0.
- busy = (valid_in && state==IDLE) || state==CALC || state==FIXUP. Never high in DONE, so the stage advances on valid_out.
- Flush:
  - flush=1 in any state → IDLE next edge; valid_out stays 0 that cycle; result not updated.
  - A flush coincident with valid_in blocks the accept.
  - A flush in DONE does not retract the current valid_out strobe, but blocks any accept.
- Disabled ops (ENABLE_* =0): go straight to DONE with result 0; latency 1.
- Reset (reset==0 at edge), including mid-operation:
  - State IDLE, counter 0, valid_out=0, result=0, busy=0.
  - ready=1 after reset deasserts.
- valid_in while not ready: ignored; no state change.

Test Plan:
- XLEN=32, UNROLL=1:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, valid_out cycle 34.
  - MULH 0x80000000² → 0x40000000.
  - MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2. busy high cycles 0..33, low at 34.
- Special cases, each with valid_out at cycle 2:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0.
- Abort and reset:
  - flush at cycle 10 of a DIV → no valid_out; ready=1 cycle 11. New MUL 3×4 accepted → 12.
  - reset=0 at cycle 5 → all outputs 0 next edge.
- Back-to-back: second op accepted in DONE cycle → its valid_out exactly N+2 cycles later; first result observed for exactly one strobe.
- XLEN=64, UNROLL=4:
  - DIVW rs1=0x00000000FFFFFFF9, rs2=2 → 0xFFFFFFFFFFFFFFFD, valid_out cycle 10.
  - MUL 64-bit 2^40 × 3 → 0x0000030000000000, valid_out cycle 18.
